// File: rtl/sram_l1veri_denetleyici_pkg.sv
// Shared types and helpers for the L1 data SRAM controller.
// Widths here are the defaults used by the controller parameters.
package l1veri_pkg;

  localparam int L1_ADDR_W   = 8;
  localparam int L1_DATA_W   = 32;
  localparam int SRAM_WORD_W = L1_DATA_W + 1;
  localparam int PARITY_BIT  = L1_DATA_W;

  typedef enum logic [2:0] {
    CLEAR  = 3'd0,
    IDLE   = 3'd1,
    ACCESS = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } l1_state_e;

  // Parity bit stored alongside the data so the full SRAM word has even parity.
  function automatic logic parity_gen(input logic [L1_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sram_l1veri_denetleyici.sv
// L1 data SRAM initiator: request stream to macro cycles, parity on writes and reads,
// optional zero-fill of the whole array after reset.
//
// state  | meaning
// CLEAR  | sweeping zeros into every word, requests held off
// IDLE   | ready for one request
// ACCESS | macro samples the registered command this cycle
// WAIT   | read data arrives from the macro, captured on exit
// RESP   | read response held until consumed
module sram_l1veri_denetleyici
  import l1veri_pkg::*;
#(
  parameter int ADDR_WIDTH     = L1_ADDR_W,
  parameter int DATA_WIDTH     = L1_DATA_W,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_parity_err_o,
  output logic                  init_done_o,
  output logic                  sram_csb_o,
  output logic                  sram_web_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH:0]   sram_din_o,
  input  logic [DATA_WIDTH:0]   sram_dout_i
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

  l1_state_e             state;
  logic [ADDR_WIDTH:0]   clr_cnt;
  logic                  accept;

  assign accept = req_valid_i & req_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state             <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_cnt           <= '0;
      req_ready_o       <= 1'b0;
      resp_valid_o      <= 1'b0;
      resp_rdata_o      <= '0;
      resp_parity_err_o <= 1'b0;
      init_done_o       <= 1'b0;
      sram_csb_o        <= 1'b1;
      sram_web_o        <= 1'b1;
      sram_addr_o       <= '0;
      sram_din_o        <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          sram_csb_o  <= 1'b0;
          sram_web_o  <= 1'b0;
          sram_din_o  <= '0;
          sram_addr_o <= clr_cnt[ADDR_WIDTH-1:0];
          clr_cnt     <= clr_cnt + CNT_ONE;
          if (clr_cnt == CNT_LAST) begin
            state       <= IDLE;
            init_done_o <= 1'b1;
            req_ready_o <= 1'b1;
          end
        end
        IDLE: begin
          // The last clear write is sampled by the macro on this edge, so a new
          // command may be registered at the same time.
          init_done_o <= 1'b1;
          sram_csb_o  <= 1'b1;
          sram_web_o  <= 1'b1;
          if (accept) begin
            sram_csb_o  <= 1'b0;
            sram_web_o  <= ~req_write_i;
            sram_addr_o <= req_addr_i;
            sram_din_o  <= {parity_gen(req_wdata_i), req_wdata_i};
            req_ready_o <= 1'b0;
            state       <= ACCESS;
          end else begin
            req_ready_o <= 1'b1;
          end
        end
        ACCESS: begin
          sram_csb_o <= 1'b1;
          sram_web_o <= 1'b1;
          if (!sram_web_o) begin
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // Macro output is only valid up to this edge.
          resp_rdata_o      <= sram_dout_i[DATA_WIDTH-1:0];
          resp_parity_err_o <= ^sram_dout_i;
          resp_valid_o      <= 1'b1;
          state             <= RESP;
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
